// File: rtl/simmem_pkg.sv
// simmem_pkg: shared definitions for the simulated-memory lane arbiter.
//   SIMMEM_DATA_WIDTH / SIMMEM_LOGSIZE_WIDTH : default bus widths
//   clog2_min1()                             : source-id width, never below 1
//   simmem_beat_t                            : one request beat at the default widths
package simmem_pkg;

  localparam int SIMMEM_DATA_WIDTH    = 64;
  localparam int SIMMEM_LOGSIZE_WIDTH = 3;

  // A single lane still needs a 1-bit source field.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [SIMMEM_DATA_WIDTH-1:0]    address;
    logic                            is_store;
    logic [SIMMEM_LOGSIZE_WIDTH-1:0] size;
    logic [SIMMEM_DATA_WIDTH-1:0]    data;
  } simmem_beat_t;

endpackage

// File: rtl/simmem_lane_arbiter_if.sv
// simmem_lane_arbiter_if: lane-flattened upstream A/D buses plus the single
// source-tagged downstream memory channel.
//   modport slave  : arbiter view (takes lane requests, drives the memory side)
//   modport master : environment view (fuzzer lanes + memory model)
interface simmem_lane_arbiter_if
  import simmem_pkg::*;
#(
  parameter int NUM_LANES     = 4,
  parameter int DATA_WIDTH    = SIMMEM_DATA_WIDTH,
  parameter int LOGSIZE_WIDTH = SIMMEM_LOGSIZE_WIDTH
);
  localparam int SRC_WIDTH = clog2_min1(NUM_LANES);

  logic [NUM_LANES-1:0]               in_a_valid;
  logic [NUM_LANES-1:0]               in_a_ready;
  logic [DATA_WIDTH*NUM_LANES-1:0]    in_a_address;
  logic [NUM_LANES-1:0]               in_a_is_store;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] in_a_size;
  logic [DATA_WIDTH*NUM_LANES-1:0]    in_a_data;
  logic [NUM_LANES-1:0]               in_d_valid;
  logic [NUM_LANES-1:0]               in_d_ready;
  logic [NUM_LANES-1:0]               in_d_is_store;
  logic [LOGSIZE_WIDTH*NUM_LANES-1:0] in_d_size;

  logic                     out_a_valid;
  logic                     out_a_ready;
  logic [DATA_WIDTH-1:0]    out_a_address;
  logic                     out_a_is_store;
  logic [LOGSIZE_WIDTH-1:0] out_a_size;
  logic [DATA_WIDTH-1:0]    out_a_data;
  logic [SRC_WIDTH-1:0]     out_a_source;
  logic                     out_d_valid;
  logic                     out_d_ready;
  logic [SRC_WIDTH-1:0]     out_d_source;
  logic                     out_d_is_store;
  logic [LOGSIZE_WIDTH-1:0] out_d_size;

  modport slave (
    input  in_a_valid, in_a_address, in_a_is_store, in_a_size, in_a_data, in_d_ready,
    input  out_a_ready, out_d_valid, out_d_source, out_d_is_store, out_d_size,
    output in_a_ready, in_d_valid, in_d_is_store, in_d_size,
    output out_a_valid, out_a_address, out_a_is_store, out_a_size, out_a_data,
    output out_a_source, out_d_ready
  );

  modport master (
    output in_a_valid, in_a_address, in_a_is_store, in_a_size, in_a_data, in_d_ready,
    output out_a_ready, out_d_valid, out_d_source, out_d_is_store, out_d_size,
    input  in_a_ready, in_d_valid, in_d_is_store, in_d_size,
    input  out_a_valid, out_a_address, out_a_is_store, out_a_size, out_a_data,
    input  out_a_source, out_d_ready
  );

endinterface

// File: rtl/simmem_rr_picker.sv
// simmem_rr_picker: combinational round-robin pick.
//   eligible  : lanes that may be granted this cycle
//   ptr       : lane with highest priority
//   grant     : one-hot grant (zero when nothing is eligible)
//   grant_idx : encoded index of the granted lane
//   grant_any : some lane was granted
module simmem_rr_picker
  import simmem_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  localparam int SRC_WIDTH = clog2_min1(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] eligible,
  input  logic [SRC_WIDTH-1:0] ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [SRC_WIDTH-1:0] grant_idx,
  output logic                 grant_any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    // Walk from the farthest offset back to ptr so the closest eligible
    // lane (in rotation order) is the one left standing.
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_LANES;
      if (eligible[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = SRC_WIDTH'(idx);
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simmem_lane_arbiter.sv
// simmem_lane_arbiter: shares one simulated-memory port between NUM_LANES
// fuzzer lanes.
//   clock, reset   : sole clock, synchronous active-high reset
//   bus (slave)    : per-lane A/D buses and the source-tagged memory channel
//   drain          : stop granting new requests
//   inflight       : a request is held or a response is still owed
//   drained        : drain && !inflight
//   err_bad_source : sticky, response for an unknown lane or an idle counter
module simmem_lane_arbiter
  import simmem_pkg::*;
#(
  parameter  int NUM_LANES       = 4,
  parameter  int DATA_WIDTH      = SIMMEM_DATA_WIDTH,
  parameter  int LOGSIZE_WIDTH   = SIMMEM_LOGSIZE_WIDTH,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int SRC_WIDTH       = clog2_min1(NUM_LANES)
) (
  input  logic                  clock,
  input  logic                  reset,
  simmem_lane_arbiter_if.slave  bus,
  input  logic                  drain,
  output logic                  inflight,
  output logic                  drained,
  output logic                  err_bad_source
);

  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    address;
    logic                     is_store;
    logic [LOGSIZE_WIDTH-1:0] size;
    logic [DATA_WIDTH-1:0]    data;
  } beat_t;

  beat_t                req_q, req_d;
  logic                 valid_q, valid_d;
  logic [SRC_WIDTH-1:0] src_q, src_d;
  logic [SRC_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_LANES];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_LANES];
  logic                 err_q, err_d;

  logic                 load_ok;
  logic [NUM_LANES-1:0] eligible;
  logic [NUM_LANES-1:0] grant;
  logic [SRC_WIDTH-1:0] grant_idx;
  logic                 accept;
  logic                 src_ok;
  logic [NUM_LANES-1:0] d_sel;
  logic                 d_fire;

  assign load_ok = !valid_q || bus.out_a_ready;

  // Reset also masks grants so lanes never see a ready while the
  // arbiter is being cleared.
  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_elig
    assign eligible[gi] = bus.in_a_valid[gi] && (cnt_q[gi] < CNT_WIDTH'(MAX_OUTSTANDING))
                          && !drain && load_ok && !reset;
  end

  simmem_rr_picker #(.NUM_LANES(NUM_LANES)) u_picker (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (accept)
  );

  assign bus.in_a_ready = grant;

  // Request register: a presented beat is only replaced once it has fired.
  always_comb begin
    req_d   = req_q;
    src_d   = src_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_ok) valid_d = accept;
    if (accept) begin
      req_d.address  = bus.in_a_address[DATA_WIDTH*grant_idx +: DATA_WIDTH];
      req_d.is_store = bus.in_a_is_store[grant_idx];
      req_d.size     = bus.in_a_size[LOGSIZE_WIDTH*grant_idx +: LOGSIZE_WIDTH];
      req_d.data     = bus.in_a_data[DATA_WIDTH*grant_idx +: DATA_WIDTH];
      src_d          = grant_idx;
      ptr_d          = (int'(grant_idx) == NUM_LANES - 1) ? '0 : grant_idx + SRC_WIDTH'(1);
    end
  end

  // Response routing is purely combinational; unknown sources are swallowed.
  assign src_ok = int'(bus.out_d_source) < NUM_LANES;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_route
    assign d_sel[gi]              = src_ok && (bus.out_d_source == SRC_WIDTH'(gi));
    assign bus.in_d_valid[gi]     = d_sel[gi] && bus.out_d_valid;
    assign bus.in_d_is_store[gi]  = d_sel[gi] && bus.out_d_is_store;
    assign bus.in_d_size[LOGSIZE_WIDTH*gi +: LOGSIZE_WIDTH] = d_sel[gi] ? bus.out_d_size : '0;
  end

  assign bus.out_d_ready = src_ok ? |(d_sel & bus.in_d_ready) : 1'b1;
  assign d_fire          = bus.out_d_valid && bus.out_d_ready;

  // Outstanding counters. A response against an idle counter is a protocol
  // error; the counter is not allowed to wrap.
  always_comb begin
    logic dec;
    err_d = err_q;
    dec   = 1'b0;
    if (d_fire && !src_ok) err_d = 1'b1;
    for (int g = 0; g < NUM_LANES; g++) begin
      cnt_d[g] = cnt_q[g];
      dec      = d_fire && d_sel[g];
      if (dec && cnt_q[g] == '0) begin
        err_d = 1'b1;
        if (grant[g]) cnt_d[g] = cnt_q[g] + CNT_WIDTH'(1);
      end else if (grant[g] && !dec) begin
        cnt_d[g] = cnt_q[g] + CNT_WIDTH'(1);
      end else if (dec && !grant[g]) begin
        cnt_d[g] = cnt_q[g] - CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int g = 0; g < NUM_LANES; g++) cnt_q[g] <= '0;
    end else begin
      req_q   <= req_d;
      src_q   <= src_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int g = 0; g < NUM_LANES; g++) cnt_q[g] <= cnt_d[g];
    end
  end

  always_comb begin
    inflight = valid_q;
    for (int g = 0; g < NUM_LANES; g++) begin
      if (cnt_q[g] != '0) inflight = 1'b1;
    end
  end

  assign drained            = drain && !inflight;
  assign err_bad_source     = err_q;
  assign bus.out_a_valid    = valid_q;
  assign bus.out_a_address  = req_q.address;
  assign bus.out_a_is_store = req_q.is_store;
  assign bus.out_a_size     = req_q.size;
  assign bus.out_a_data     = req_q.data;
  assign bus.out_a_source   = src_q;

endmodule
